// File: rtl/uart_pkg.sv
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int unsigned MIN_DIV     = 2;
  localparam int unsigned DEFAULT_DIV = 106;

endpackage

// File: rtl/sync_fifo.sv
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
module uart_tx_fifo #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned DEFAULT_DIV = uart_pkg::DEFAULT_DIV
) (
  input  logic                     clk,
  input  logic                     resetn,
  output logic                     ser_tx,
  input  logic [3:0]               reg_div_we,
  input  logic [31:0]              reg_div_di,
  output logic [31:0]              reg_div_do,
  input  logic                     reg_dat_we,
  input  logic [7:0]               reg_dat_di,
  output logic                     reg_dat_wait,
  output logic [$clog2(DEPTH):0]   tx_level,
  output logic                     tx_idle
);

  import uart_pkg::*;

  logic [31:0] div_q;
  logic [31:0] eff_div;
  tx_state_t   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [31:0] cur_div_q, cur_div_d;
  logic [31:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        bit_end;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (reg_dat_we),
    .pop    (fifo_pop),
    .din    (reg_dat_di),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (tx_level)
  );

  assign reg_dat_wait = reg_dat_we && fifo_full;
  assign reg_div_do   = div_q;
  assign eff_div      = (div_q < MIN_DIV) ? MIN_DIV : div_q;
  assign bit_end      = (clk_cnt_q == cur_div_q - 32'd1);
  assign tx_idle      = (state_q == IDLE) && fifo_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q <= DEFAULT_DIV;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (reg_div_we[i]) div_q[i*8 +: 8] <= reg_div_di[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cur_div_q <= '0;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cur_div_q <= cur_div_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  // The pop path is shared by IDLE and end-of-STOP so frames chain with no gap.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cur_div_d = cur_div_q;
    bit_idx_d = bit_idx_q;
    clk_cnt_d = bit_end ? '0 : clk_cnt_q + 32'd1;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_dout;
          cur_div_d = eff_div;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_dout;
            cur_div_d = eff_div;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      START:   ser_tx = 1'b0;
      DATA:    ser_tx = shift_q[0];
      default: ser_tx = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter for the PicoSoC serial port: accepts bytes from the CPU through a picosoc-style memory-mapped data/divider register pair and serialises them, 8N1, LSB first, onto the board `RsTx` line (`ser_tx`). It is the stage directly upstream of the serial line that the Basys3 top-level bench decodes at 106 clocks/bit. A FIFO decouples CPU writes from line timing, so the CPU stalls only when the FIFO is full.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `DEFAULT_DIV`, 106: reset value of the divider register, in clocks per bit.
- `clk`  in  1  system clock.
- `resetn`  in  1  reset; asynchronous, active-low.
- `ser_tx`  out  1  serial output; idle high.
- `reg_div_we`  in  4  byte enables for the divider write.
- `reg_div_di`  in  32  divider write data.
- `reg_div_do`  out  32  stored divider value.
- `reg_dat_we`  in  1  data write strobe; held high by the bus until it is accepted.
- `reg_dat_di`  in  8  byte to transmit.
- `reg_dat_wait`  out  1  stall; combinational, equal to `reg_dat_we && full`.
- `tx_level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `tx_idle`  out  1  high when the FSM is in IDLE and the FIFO is empty.

## Operation
- **Reset values:** `ser_tx`=1, `reg_div_do`=DEFAULT_DIV, `tx_level`=0, `tx_idle`=1, FSM in IDLE.
- **Push:** a push occurs on any cycle with `reg_dat_we && !full`. Bytes written while full are stalled, never dropped.
- **Divider register:** byte-enabled write, updated at the clock edge. Effective divider = max(stored, 2). Reads return the stored value, unclamped.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** if the FIFO is non-empty, pop the head byte into the shift register, latch the effective divider into `cur_div`, and go to START.
  - **START:** `ser_tx`=0 for `cur_div` clocks, then go to DATA with `bit_idx`=0.
  - **DATA:** `ser_tx`=shift[0] for `cur_div` clocks, then shift right and increment `bit_idx`. After bit 7, go to STOP.
  - **STOP:** `ser_tx`=1 for `cur_div` clocks. At the end of STOP, if the FIFO is non-empty, pop and go straight to START; otherwise go to IDLE.
- **Bit counter:** `clk_cnt` is 32 bits and counts 0..`cur_div`-1; the bit ends when `clk_cnt`==`cur_div`-1.
- **Divider writes mid-frame:** they do not affect the frame in progress.
- **Simultaneous push and pop:** `tx_level` is unchanged. `full`/`empty` are derived from registered pointers, so a pop does not release a stalled write in the same cycle.
- **Pointers:** wrap modulo DEPTH, with an extra MSB to distinguish full from empty.
- **Reset mid-frame:** asynchronously forces `ser_tx` high, empties the FIFO, restores the divider and returns the FSM to IDLE. The partial frame is abandoned.

## Timing
- **Start latency:** with an idle, empty block, a write sampled at edge E0 makes the FIFO non-empty after E0. IDLE pops at E1, and `ser_tx` falls after E1.
- **Frame length:** exactly 10·`cur_div` clocks. Back-to-back frames have no gap: the next start bit begins the clock after the stop bit's last cycle.
- **`tx_idle`:** rises the cycle after the final stop-bit cycle when the FIFO is empty.
- **`tx_level`:** registered, and reflects a push or pop one edge after it occurs.
- **`reg_dat_wait`:** combinational from `reg_dat_we` and the registered `full`.

## Structure
- **Shared package `uart_pkg`:** FSM state encoding (IDLE/START/DATA/STOP), `MIN_DIV`=2, and the DEFAULT_DIV constant used by the SoC top.
- **Sub-module `sync_fifo`:** parameterised width/depth, single clock, async active-low reset. It provides `push`, `pop`, `din`, `dout`, `full`, `empty` and `level`, with `dout` showing the head combinationally.
- **Top:** holds the divider register, FSM, bit/clock counters and shift register.

## Test plan
- **Reset:** assert `resetn`=0, then release → `ser_tx`=1, `reg_div_do`=106, `tx_level`=0, `tx_idle`=1.
- **Single byte:** write 0x55 at div 106 → `ser_tx` low one edge after acceptance. Each bit lasts 106 clocks; the line decodes 'U' and `tx_idle`=1 after 1060 clocks.
- **Burst of 18 bytes, 0x30..0x41, back to back:**
  - Byte 0 is popped immediately and 16 bytes fill the FIFO.
  - The 18th write sees `reg_dat_wait`=1 until byte 1 is popped (~1060 clocks later).
  - All 18 bytes decode in order with no idle gap.
- **Divider change mid-frame:** write div=20 halfway through 0xA5 → 0xA5 completes at 106 clocks/bit; the next byte is sent at 20 clocks/bit.
- **Divider clamp:** write div=1 → `reg_div_do` reads 1; the bit period measures 2 clocks.
- **Reset mid-frame:** with 4 bytes queued, pulse `resetn` low during DATA → `ser_tx`=1 immediately and `tx_level`=0. No further frames are sent after release.
